// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C transaction sequencer and its neighbours:
//   - default data / byte-count widths
//   - byte-engine command encodings (START=0, WRITE=1, READ=2, STOP=3)
//   - sequencer state enumeration
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } eng_cmd_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_TX_FETCH,
        S_TX_WAIT,
        S_TX_BYTE,
        S_RX_BYTE,
        S_RX_PUSH,
        S_STOP,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/i2c_fifo_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_fifo_sequencer
// Runs one I2C transaction per accepted `go`: START, address byte, then data
// bytes drained from the TX FIFO (write) or pushed into the RX FIFO (read),
// then STOP. Owns every FIFO strobe while busy; reports done / NACK status.
//
// Ports
//   i_clk, reset             clock, synchronous active-high reset
//   go, slave_addr, rw,
//   byte_count               command; latched when `go` is accepted in IDLE
//   busy, done               status: busy through DONE, one-cycle done pulse
//   nack_err, rx_drop        sticky status, cleared on accepted `go`
//   tx_empty, tx_rd_request,
//   tx_rd_data               TX FIFO pop side (registered read data)
//   rx_full, rx_wr_request,
//   rx_wr_data               RX FIFO push side
//   eng_start, eng_cmd,
//   eng_wdata, eng_last      command to the byte engine
//   eng_done, eng_ack,
//   eng_rdata                completion from the byte engine
//
// Build option
//   I2C_SEQ_RX_BACKPRESSURE_EN  defined: RX_PUSH waits for RX FIFO space and
//                               rx_drop never sets. Undefined: push at once,
//                               a push into a full FIFO sets rx_drop.
// ---------------------------------------------------------------------------
module i2c_fifo_sequencer
    import i2c_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             go,
    input  logic [6:0]       slave_addr,
    input  logic             rw,
    input  logic [CNT_W-1:0] byte_count,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic             rx_drop,
    input  logic             tx_empty,
    output logic             tx_rd_request,
    input  logic [W-1:0]     tx_rd_data,
    input  logic             rx_full,
    output logic             rx_wr_request,
    output logic [W-1:0]     rx_wr_data,
    output logic             eng_start,
    output logic [1:0]       eng_cmd,
    output logic [W-1:0]     eng_wdata,
    output logic             eng_last,
    input  logic             eng_done,
    input  logic             eng_ack,
    input  logic [W-1:0]     eng_rdata
);

    seq_state_t       state_reg, state_next;
    logic [6:0]       addr_reg, addr_next;
    logic             rw_reg, rw_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic             nack_reg, nack_next;
    logic             drop_reg, drop_next;
    logic             done_reg, done_next;
    logic             tx_rd_reg, tx_rd_next;
    logic             rx_wr_reg, rx_wr_next;
    logic             eng_start_reg, eng_start_next;
    logic             eng_last_reg, eng_last_next;
    eng_cmd_t         eng_cmd_reg, eng_cmd_next;
    logic [W-1:0]     eng_wdata_reg, eng_wdata_next;
    logic [W-1:0]     rx_wr_data_reg, rx_wr_data_next;

    logic             enter_stop;
    logic             enter_rx;
    logic             push_complete;
    logic [CNT_W-1:0] remaining_dec;

    // Saturating decrement: the counter never wraps below zero.
    assign remaining_dec = (remaining_reg == '0) ? '0 : remaining_reg - CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            rw_reg         <= 1'b0;
            remaining_reg  <= '0;
            nack_reg       <= 1'b0;
            drop_reg       <= 1'b0;
            done_reg       <= 1'b0;
            tx_rd_reg      <= 1'b0;
            rx_wr_reg      <= 1'b0;
            eng_start_reg  <= 1'b0;
            eng_last_reg   <= 1'b0;
            eng_cmd_reg    <= CMD_START;
            eng_wdata_reg  <= '0;
            rx_wr_data_reg <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            rw_reg         <= rw_next;
            remaining_reg  <= remaining_next;
            nack_reg       <= nack_next;
            drop_reg       <= drop_next;
            done_reg       <= done_next;
            tx_rd_reg      <= tx_rd_next;
            rx_wr_reg      <= rx_wr_next;
            eng_start_reg  <= eng_start_next;
            eng_last_reg   <= eng_last_next;
            eng_cmd_reg    <= eng_cmd_next;
            eng_wdata_reg  <= eng_wdata_next;
            rx_wr_data_reg <= rx_wr_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        rw_next         = rw_reg;
        remaining_next  = remaining_reg;
        nack_next       = nack_reg;
        drop_next       = drop_reg;
        eng_cmd_next    = eng_cmd_reg;
        eng_wdata_next  = eng_wdata_reg;
        rx_wr_data_next = rx_wr_data_reg;
        eng_last_next   = eng_last_reg;
        // Strobes are single-cycle: they fall unless re-armed below.
        done_next       = 1'b0;
        tx_rd_next      = 1'b0;
        rx_wr_next      = 1'b0;
        eng_start_next  = 1'b0;
        enter_stop      = 1'b0;
        enter_rx        = 1'b0;
        push_complete   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    addr_next      = slave_addr;
                    rw_next        = rw;
                    remaining_next = byte_count;
                    nack_next      = 1'b0;
                    drop_next      = 1'b0;
                    state_next     = S_START;
                    eng_start_next = 1'b1;
                    eng_cmd_next   = CMD_START;
                end
            end
            S_START: begin
                if (eng_done) begin
                    state_next     = S_ADDR;
                    eng_start_next = 1'b1;
                    eng_cmd_next   = CMD_WRITE;
                    eng_wdata_next = W'({addr_reg, rw_reg});
                end
            end
            S_ADDR: begin
                if (eng_done) begin
                    if (!eng_ack) begin
                        nack_next  = 1'b1;
                        enter_stop = 1'b1;
                    end else if (remaining_reg == '0) begin
                        enter_stop = 1'b1;
                    end else if (rw_reg) begin
                        enter_rx   = 1'b1;
                    end else begin
                        state_next = S_TX_FETCH;
                    end
                end
            end
            S_TX_FETCH: begin
                if (!tx_empty) begin
                    tx_rd_next = 1'b1;
                    state_next = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                // First cycle here is the pop itself; the FIFO's registered
                // data is valid on the following cycle, which is when we take it.
                if (!tx_rd_reg) begin
                    eng_wdata_next = tx_rd_data;
                    state_next     = S_TX_BYTE;
                    eng_start_next = 1'b1;
                    eng_cmd_next   = CMD_WRITE;
                end
            end
            S_TX_BYTE: begin
                if (eng_done) begin
                    remaining_next = remaining_dec;
                    if (!eng_ack) begin
                        nack_next  = 1'b1;
                        enter_stop = 1'b1;
                    end else if (remaining_dec == '0) begin
                        enter_stop = 1'b1;
                    end else begin
                        state_next = S_TX_FETCH;
                    end
                end
            end
            S_RX_BYTE: begin
                if (eng_done) begin
                    rx_wr_data_next = eng_rdata;
                    state_next      = S_RX_PUSH;
`ifndef I2C_SEQ_RX_BACKPRESSURE_EN
                    rx_wr_next      = 1'b1;
`endif
                end
            end
            S_RX_PUSH: begin
`ifdef I2C_SEQ_RX_BACKPRESSURE_EN
                // Only this block pushes the RX FIFO, so space seen now is
                // still there when the registered strobe fires next cycle.
                if (rx_wr_reg) begin
                    push_complete = 1'b1;
                end else if (!rx_full) begin
                    rx_wr_next = 1'b1;
                end
`else
                if (rx_full) begin
                    drop_next = 1'b1;
                end
                push_complete = 1'b1;
`endif
            end
            S_STOP: begin
                if (eng_done) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (push_complete) begin
            remaining_next = remaining_dec;
            if (remaining_dec == '0) begin
                enter_stop = 1'b1;
            end else begin
                enter_rx = 1'b1;
            end
        end

        if (enter_stop) begin
            state_next     = S_STOP;
            eng_start_next = 1'b1;
            eng_cmd_next   = CMD_STOP;
        end

        if (enter_rx) begin
            state_next     = S_RX_BYTE;
            eng_start_next = 1'b1;
            eng_cmd_next   = CMD_READ;
        end

        // eng_last only carries meaning on READ; other commands clear it.
        if (enter_rx) begin
            eng_last_next = (remaining_next == CNT_W'(1));
        end else if (eng_start_next) begin
            eng_last_next = 1'b0;
        end
    end

    assign busy          = (state_reg != S_IDLE);
    assign done          = done_reg;
    assign nack_err      = nack_reg;
    assign rx_drop       = drop_reg;
    assign tx_rd_request = tx_rd_reg;
    assign rx_wr_request = rx_wr_reg;
    assign rx_wr_data    = rx_wr_data_reg;
    assign eng_start     = eng_start_reg;
    assign eng_cmd       = eng_cmd_reg;
    assign eng_wdata     = eng_wdata_reg;
    assign eng_last      = eng_last_reg;

endmodule

// File: tb/tb_i2c_fifo_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_fifo_sequencer
// Self-checking bench for i2c_fifo_sequencer. A single initial block plays
// the TX/RX FIFOs and the byte engine cycle by cycle, logs every command,
// pop and push, and compares against a transaction-level model that lists
// the expected engine commands and FIFO traffic from the command alone.
// Honours I2C_SEQ_RX_BACKPRESSURE_EN for the RX-full expectations.
// ---------------------------------------------------------------------------
module tb_i2c_fifo_sequencer;
    import i2c_pkg::*;

`ifdef I2C_SEQ_RX_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       reset, go, rw, busy, done, nack_err, rx_drop;
    logic [6:0] slave_addr;
    logic [7:0] byte_count;
    logic       tx_empty, tx_rd_request, rx_full, rx_wr_request;
    logic [7:0] tx_rd_data, rx_wr_data, eng_wdata, eng_rdata;
    logic       eng_start, eng_last, eng_done, eng_ack;
    logic [1:0] eng_cmd;

    int checks = 0;
    int errors = 0;
    logic [7:0] preset_q[$];

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       last;
    } ev_t;

    i2c_fifo_sequencer #(.W(8), .CNT_W(8)) dut (
        .i_clk(i_clk), .reset(reset), .go(go), .slave_addr(slave_addr),
        .rw(rw), .byte_count(byte_count), .busy(busy), .done(done),
        .nack_err(nack_err), .rx_drop(rx_drop), .tx_empty(tx_empty),
        .tx_rd_request(tx_rd_request), .tx_rd_data(tx_rd_data),
        .rx_full(rx_full), .rx_wr_request(rx_wr_request),
        .rx_wr_data(rx_wr_data), .eng_start(eng_start), .eng_cmd(eng_cmd),
        .eng_wdata(eng_wdata), .eng_last(eng_last), .eng_done(eng_done),
        .eng_ack(eng_ack), .eng_rdata(eng_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] c, input logic [7:0] d, input logic l);
        ev_t e;
        e.cmd = c; e.data = d; e.last = l;
        return e;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, done, nack_err, rx_drop, tx_rd_request, rx_wr_request,
                  eng_start, eng_last, eng_cmd, eng_wdata, rx_wr_data}, 32'h0);
    endtask

    // nack_at: -1 none, 0 address byte, k>=1 data byte k.
    // full_at: read byte index whose push meets a full RX FIFO, -1 none.
    // fill_cyc: 0 = TX FIFO loaded before go, else loaded at that cycle.
    task automatic run_txn(input logic [6:0] a, input logic r, input int cnt,
                           input int nack_at, input int full_at, input int fill_cyc,
                           input bit go_busy, input bit abort);
        ev_t exp_q[$];
        ev_t act_q[$];
        logic [7:0] txb[$];
        logic [7:0] rdb[$];
        logic [7:0] fifo[$];
        logic [7:0] exp_rx[$];
        logic [7:0] act_rx[$];
        logic [7:0] pend = 8'h00;
        logic [1:0] out_cmd = 2'd0;
        int exp_pops = 0, pops = 0, n_done = 0, drops_seen = 0, cyc = 0;
        int wr_idx = 0, rd_idx = 0, cd = 0, last_done_cyc = 0, pop_cyc = 0;
        int full_cnt = 0, nmin;
        bit outst = 0, pend_v = 0, prev_read = 0, finished = 0;
        bit exp_nack = 0, exp_drop = 0;

        for (int i = 0; i < cnt; i++) begin
            if (i < preset_q.size()) begin
                txb.push_back(preset_q[i]);
                rdb.push_back(preset_q[i]);
            end else begin
                txb.push_back(8'($urandom_range(0, 255)));
                rdb.push_back(8'($urandom_range(0, 255)));
            end
        end
        preset_q.delete();

        // Transaction-level expectation.
        exp_q.push_back(mk(CMD_START, 8'h00, 1'b0));
        exp_q.push_back(mk(CMD_WRITE, {a, r}, 1'b0));
        exp_nack = (nack_at == 0);
        if (nack_at != 0) begin
            for (int k = 0; k < cnt; k++) begin
                if (!r) begin
                    exp_q.push_back(mk(CMD_WRITE, txb[k], 1'b0));
                    exp_pops++;
                    if (k + 1 == nack_at) begin
                        exp_nack = 1;
                        break;
                    end
                end else begin
                    exp_q.push_back(mk(CMD_READ, 8'h00, k == cnt - 1));
                    if (k == full_at && !BP) exp_drop = 1;
                    else exp_rx.push_back(rdb[k]);
                end
            end
        end
        exp_q.push_back(mk(CMD_STOP, 8'h00, 1'b0));

        if (fill_cyc == 0) fifo = txb;
        @(negedge i_clk);
        tx_empty = (fifo.size() == 0);
        slave_addr = a; rw = r; byte_count = 8'(cnt); go = 1'b1;

        for (int it = 0; it < 3000 && !finished; it++) begin
            @(negedge i_clk);
            cyc++;
            if (cyc == 1 || cyc == 4) go = 1'b0;
            if (cyc == 1) begin
                chk("go_to_start", {busy, eng_start, eng_cmd}, {1'b1, 1'b1, CMD_START});
                chk("sticky_clear_on_go", {nack_err, rx_drop}, 2'b00);
            end
            if (go_busy && cyc == 3) begin
                go = 1'b1; slave_addr = ~a; rw = ~r; byte_count = 8'd7;
            end
            eng_done = 1'b0;
            if (pend_v) begin
                tx_rd_data = pend;
                pend_v = 0;
            end
            if (full_cnt > 0) begin
                full_cnt--;
                if (full_cnt == 0) rx_full = 1'b0;
            end
            if (fill_cyc > 0 && cyc == fill_cyc) fifo = txb;

            if (eng_start) begin
                if (outst) chk("start_while_engine_busy", 1, 0);
                act_q.push_back(mk(eng_cmd, eng_wdata, eng_last));
                if (eng_cmd == CMD_WRITE && act_q.size() >= 3)
                    chk("pop_to_write_start", cyc - pop_cyc, 2);
                else if (act_q.size() >= 2 && !prev_read)
                    chk("done_to_next_start", cyc - last_done_cyc, 1);
                if (abort && eng_cmd == CMD_WRITE && act_q.size() == 3) begin
                    reset = 1'b1;
                    @(negedge i_clk);
                    reset = 1'b0;
                    rx_full = 1'b0; go = 1'b0; tx_empty = 1'b1;
                    chk_all_zero("reset_mid_txn");
                    for (int j = 0; j < 3; j++) begin
                        @(negedge i_clk);
                        chk("no_activity_after_reset",
                            {busy, eng_start, tx_rd_request, rx_wr_request, done}, 5'b0);
                    end
                    return;
                end
                outst = 1;
                out_cmd = eng_cmd;
                cd = $urandom_range(1, 3);
            end else if (outst) begin
                cd--;
                if (cd == 0) begin
                    eng_done = 1'b1;
                    outst = 0;
                    last_done_cyc = cyc;
                    prev_read = (out_cmd == CMD_READ);
                    eng_ack = 1'($urandom_range(0, 1));
                    eng_rdata = 8'($urandom_range(0, 255));
                    if (out_cmd == CMD_WRITE) begin
                        eng_ack = (wr_idx != nack_at);
                        wr_idx++;
                    end
                    if (out_cmd == CMD_READ && rd_idx < cnt) begin
                        eng_rdata = rdb[rd_idx];
                        if (rd_idx == full_at) begin
                            rx_full = 1'b1;
                            full_cnt = 2;
                        end
                        rd_idx++;
                    end
                end
            end

            if (tx_rd_request) begin
                pops++;
                if (fifo.size() == 0) chk("pop_of_empty_fifo", 1, 0);
                else begin
                    pend = fifo.pop_front();
                    pend_v = 1;
                    tx_rd_data = 8'($urandom_range(0, 255));
                    pop_cyc = cyc;
                end
            end
            tx_empty = (fifo.size() == 0);

            if (rx_wr_request) begin
                if (rx_full) drops_seen++;
                else act_rx.push_back(rx_wr_data);
            end
            if (done) begin
                n_done++;
                chk("busy_during_done", busy, 1);
            end else if (n_done > 0 && !busy) begin
                finished = 1;
            end
        end

        if (!finished) chk("transaction_timeout", 0, 1);
        chk("cmd_count", act_q.size(), exp_q.size());
        nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            chk($sformatf("cmd[%0d]", i), act_q[i].cmd, exp_q[i].cmd);
            if (exp_q[i].cmd == CMD_WRITE)
                chk($sformatf("wdata[%0d]", i), act_q[i].data, exp_q[i].data);
            if (exp_q[i].cmd == CMD_READ)
                chk($sformatf("last[%0d]", i), act_q[i].last, exp_q[i].last);
        end
        chk("tx_pops", pops, exp_pops);
        chk("rx_push_count", act_rx.size(), exp_rx.size());
        nmin = (act_rx.size() < exp_rx.size()) ? act_rx.size() : exp_rx.size();
        for (int i = 0; i < nmin; i++)
            chk($sformatf("rx_data[%0d]", i), act_rx[i], exp_rx[i]);
        chk("dropped_pushes", drops_seen, exp_drop ? 1 : 0);
        chk("done_pulses", n_done, 1);
        chk("nack_err", nack_err, exp_nack);
        chk("rx_drop", rx_drop, exp_drop);
        $display("txn addr=%02h rw=%0d cnt=%0d nack_at=%0d full_at=%0d cmds=%0d pops=%0d rx=%0d nack=%0d drop=%0d",
                 a, r, cnt, nack_at, full_at, act_q.size(), pops, act_rx.size(), nack_err, rx_drop);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; rw = 1'b0; slave_addr = '0; byte_count = '0;
        tx_empty = 1'b1; tx_rd_data = '0; rx_full = 1'b0;
        eng_done = 1'b0; eng_ack = 1'b0; eng_rdata = '0;
        repeat (3) @(negedge i_clk);
        reset = 1'b0;
        @(negedge i_clk);
        chk_all_zero("reset_state");

        // Write 0x50, two bytes, all ACK.
        preset_q = '{8'hA5, 8'h3C};
        run_txn(7'h50, 1'b0, 2, -1, -1, 0, 1'b0, 1'b0);
        // Read 0x50, three bytes.
        preset_q = '{8'h11, 8'h22, 8'h33};
        run_txn(7'h50, 1'b1, 3, -1, -1, 0, 1'b0, 1'b0);
        // NACK on first data byte; nack_err must stay set while idle.
        run_txn(7'h50, 1'b0, 2, 1, -1, 0, 1'b0, 1'b0);
        repeat (5) @(negedge i_clk);
        chk("nack_err_sticky", nack_err, 1);
        // TX FIFO empty for a while, then filled with 0x7E.
        preset_q = '{8'h7E};
        run_txn(7'h50, 1'b0, 1, -1, -1, 20, 1'b0, 1'b0);
        // RX FIFO full at the second push.
        run_txn(7'h50, 1'b1, 2, -1, 1, 0, 1'b0, 1'b0);
        repeat (4) @(negedge i_clk);
        chk("rx_drop_sticky", rx_drop, !BP);
        // Address-only transaction and address NACK on a read.
        run_txn(7'h2A, 1'b0, 0, -1, -1, 0, 1'b0, 1'b0);
        run_txn(7'h3B, 1'b1, 2, 0, -1, 0, 1'b0, 1'b0);
        // go while busy is ignored.
        run_txn(7'h44, 1'b0, 3, -1, -1, 0, 1'b1, 1'b0);
        // Reset during the first data byte.
        run_txn(7'h44, 1'b0, 3, -1, -1, 0, 1'b1, 1'b1);
        $display("txn reset mid-transfer done");

        for (int n = 0; n < 12; n++) begin
            logic r;
            int cnt, nk, fa, fc;
            r   = 1'($urandom_range(0, 1));
            cnt = $urandom_range(0, 5);
            nk  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt) : -1;
            fa  = (r && cnt > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, cnt - 1) : -1;
            fc  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 15);
            run_txn(7'($urandom_range(0, 127)), r, cnt, nk, fa, fc, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
